// File: rtl/vga_pkg.sv
// Shared definitions for the VGA register scanner: FSM states, RTC register
// map addresses and the fixed scan order.
package vga_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned NENTRY_DEFAULT  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    NEXT  = 2'd3
  } state_t;

  // RTC register map; 50 is reserved and never read.
  localparam logic [ADDR_W-1:0] ADDR_SEG_RELOJ  = 8'd40;
  localparam logic [ADDR_W-1:0] ADDR_MIN_RELOJ  = 8'd41;
  localparam logic [ADDR_W-1:0] ADDR_HORA_RELOJ = 8'd42;
  localparam logic [ADDR_W-1:0] ADDR_DIA_FECHA  = 8'd43;
  localparam logic [ADDR_W-1:0] ADDR_MES_FECHA  = 8'd44;
  localparam logic [ADDR_W-1:0] ADDR_ANIO_FECHA = 8'd45;
  localparam logic [ADDR_W-1:0] ADDR_SEG_TIMER  = 8'd46;
  localparam logic [ADDR_W-1:0] ADDR_MIN_TIMER  = 8'd47;
  localparam logic [ADDR_W-1:0] ADDR_HORA_TIMER = 8'd48;
  localparam logic [ADDR_W-1:0] ADDR_FMT_CTL    = 8'd49;
  localparam logic [ADDR_W-1:0] ADDR_CURSOR_CTL = 8'd51;

  // Scan table lookup: entry index -> register address.
  function automatic logic [ADDR_W-1:0] scanAddr(input logic [7:0] idx);
    logic [ADDR_W-1:0] a;
    case (idx)
      8'd0:    a = ADDR_SEG_RELOJ;
      8'd1:    a = ADDR_MIN_RELOJ;
      8'd2:    a = ADDR_HORA_RELOJ;
      8'd3:    a = ADDR_DIA_FECHA;
      8'd4:    a = ADDR_MES_FECHA;
      8'd5:    a = ADDR_ANIO_FECHA;
      8'd6:    a = ADDR_SEG_TIMER;
      8'd7:    a = ADDR_MIN_TIMER;
      8'd8:    a = ADDR_HORA_TIMER;
      8'd9:    a = ADDR_FMT_CTL;
      8'd10:   a = ADDR_CURSOR_CTL;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/vga_reg_scanner.sv
// Walks the RTC register table once per VSync falling edge, reading each
// register and forwarding it to the display pointer stage while VSync is low.
module vga_reg_scanner
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned NENTRY  = NENTRY_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VSync,
  output logic              RdReq,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdAck,
  output logic [ADDR_W-1:0] MemAddrOut,
  output logic [DATA_W-1:0] MemDataOut,
  output logic              Write,
  output logic              Busy,
  output logic              ScanDone,
  output logic              TimeoutErr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = (NENTRY > 1) ? $clog2(NENTRY) : 1;

  state_t             state, stateNext;
  logic               vsQ;
  logic               fall;
  logic [IDX_W-1:0]   idx, idxNext;
  logic [CNT_W-1:0]   cnt, cntInc;
  logic               lastEntry;
  logic               timeoutHit;

  logic               rdReqNxt;
  logic [ADDR_W-1:0]  rdAddrNxt;
  logic [ADDR_W-1:0]  memAddrNxt;
  logic [DATA_W-1:0]  memDataNxt;
  logic               writeNxt;
  logic               busyNxt;
  logic               scanDoneNxt;
  logic               timeoutErrNxt;
  logic [CNT_W-1:0]   cntNxt;

  assign fall       = vsQ & ~VSync;
  assign lastEntry  = (idx == IDX_W'(NENTRY - 1));
  // Counter value including the current REQ cycle; REQ lasts TIMEOUT cycles.
  assign cntInc     = cnt + CNT_W'(1);
  assign timeoutHit = (cntInc == CNT_W'(TIMEOUT));

  // State, index, counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      vsQ        <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      RdReq      <= 1'b0;
      RdAddr     <= '0;
      MemAddrOut <= '0;
      MemDataOut <= '0;
      Write      <= 1'b0;
      Busy       <= 1'b0;
      ScanDone   <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      vsQ        <= VSync;
      idx        <= idxNext;
      cnt        <= cntNxt;
      RdReq      <= rdReqNxt;
      RdAddr     <= rdAddrNxt;
      MemAddrOut <= memAddrNxt;
      MemDataOut <= memDataNxt;
      Write      <= writeNxt;
      Busy       <= busyNxt;
      ScanDone   <= scanDoneNxt;
      TimeoutErr <= timeoutErrNxt;
    end
  end

  // Next-state and entry index selection.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    case (state)
      IDLE: begin
        if (fall) begin
          stateNext = REQ;
          idxNext   = '0;
        end
      end
      REQ: begin
        if (RdAck) begin
          stateNext = WRITE;
        end else if (timeoutHit) begin
          stateNext = NEXT;
        end
      end
      WRITE: begin
        // Write already strobed this cycle: the entry is done.
        if (Write) begin
          stateNext = NEXT;
        end
      end
      NEXT: begin
        if (lastEntry) begin
          stateNext = IDLE;
        end else begin
          stateNext = REQ;
          idxNext   = idx + IDX_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    rdReqNxt      = (stateNext == REQ);
    rdAddrNxt     = RdAddr;
    memAddrNxt    = MemAddrOut;
    memDataNxt    = MemDataOut;
    writeNxt      = (stateNext == WRITE) && !VSync;
    busyNxt       = (stateNext != IDLE);
    scanDoneNxt   = (state == NEXT) && lastEntry;
    timeoutErrNxt = TimeoutErr;
    cntNxt        = '0;

    if (stateNext == REQ) begin
      rdAddrNxt = scanAddr(8'(idxNext));
    end
    if ((state == REQ) && (stateNext == REQ)) begin
      cntNxt = cntInc;
    end
    if ((state == REQ) && RdAck) begin
      memAddrNxt = RdAddr;
      memDataNxt = RdData;
    end
    if ((state == IDLE) && fall) begin
      timeoutErrNxt = 1'b0;
    end
    if ((state == REQ) && !RdAck && timeoutHit) begin
      timeoutErrNxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_reg_scanner.sv
// Directed bench for vga_reg_scanner: a cycle table for latency/handshake
// details, then whole-scan sequences driven by an RTC responder model.
module tb_vga_reg_scanner;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       VSync = 1'b1;
  logic       RdReq;
  logic [7:0] RdAddr;
  logic [7:0] RdData;
  logic       RdAck;
  logic [7:0] MemAddrOut;
  logic [7:0] MemDataOut;
  logic       Write;
  logic       Busy;
  logic       ScanDone;
  logic       TimeoutErr;

  // Bus driven either by the table or by the responder model
  logic       respEn = 1'b0;
  logic       respAck = 1'b0;
  logic [7:0] respData = 8'd0;
  logic       tbAck = 1'b0;
  logic [7:0] tbData = 8'd0;
  logic [7:0] skipAddr = 8'd0;

  assign RdAck  = respEn ? respAck  : tbAck;
  assign RdData = respEn ? respData : tbData;

  int nTests = 0;
  int nFail  = 0;

  // Monitor log
  logic [7:0] wrAddrLog [256];
  logic [7:0] wrDataLog [256];
  int wrN    = 0;
  int doneN  = 0;
  int req44N = 0;
  int wrHigh = 0;

  vga_reg_scanner dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .VSync     (VSync),
    .RdReq     (RdReq),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .RdAck     (RdAck),
    .MemAddrOut(MemAddrOut),
    .MemDataOut(MemDataOut),
    .Write     (Write),
    .Busy      (Busy),
    .ScanDone  (ScanDone),
    .TimeoutErr(TimeoutErr)
  );

  always #5 CLK = ~CLK;

  // RTC model: acks the first cycle of each request with data = addr + 1
  always @(negedge CLK) begin
    if (RdReq && !respAck && (RdAddr != skipAddr)) begin
      respAck  = 1'b1;
      respData = RdAddr + 8'd1;
    end else begin
      respAck  = 1'b0;
    end
  end

  // Output monitor, sampled shortly after each active edge
  always begin
    @(posedge CLK);
    #2;
    if (Write) begin
      if (wrN < 256) begin
        wrAddrLog[wrN] = MemAddrOut;
        wrDataLog[wrN] = MemDataOut;
      end
      wrN = wrN + 1;
      if (VSync) wrHigh = wrHigh + 1;
    end
    if (ScanDone) doneN = doneN + 1;
    if (RdReq && RdAddr == 8'd44) req44N = req44N + 1;
  end

  typedef struct packed {
    logic       rdReq;
    logic [7:0] rdAddr;
    logic [7:0] memAddr;
    logic [7:0] memData;
    logic       write;
    logic       busy;
    logic       scanDone;
    logic       tmoErr;
  } outs_t;

  typedef struct {
    logic       vs;
    logic       ack;
    logic [7:0] data;
    outs_t      exp;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic vs, input logic ack, input logic [7:0] data,
                              input logic rq, input logic [7:0] ra, input logic [7:0] ma,
                              input logic [7:0] md, input logic wr, input logic bz,
                              input logic sd, input logic te);
    vec_t v;
    v.vs   = vs;
    v.ack  = ack;
    v.data = data;
    v.exp  = '{rq, ra, ma, md, wr, bz, sd, te};
    return v;
  endfunction

  function automatic outs_t actual();
    return '{RdReq, RdAddr, MemAddrOut, MemDataOut, Write, Busy, ScanDone, TimeoutErr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests = nTests + 1;
    if (act !== exp) begin
      nFail = nFail + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic doReset();
    @(negedge CLK);
    RESET = 1'b1;
    VSync = 1'b1;
    cyc(2);
    RESET = 1'b0;
    respEn = 1'b1;
  endtask

  task automatic startScan();
    VSync = 1'b1;
    cyc(2);
    VSync = 1'b0;
  endtask

  task automatic waitDone(input string nm, input int doneBase, input int budget);
    int k;
    k = 0;
    while (doneN <= doneBase && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (doneN <= doneBase) begin
      nTests = nTests + 1;
      nFail  = nFail + 1;
      $display("FAIL %s: ScanDone not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic waitReqAddr(input string nm, input logic [7:0] a, input int budget);
    int k;
    k = 0;
    while (!(RdReq && RdAddr == a) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (!(RdReq && RdAddr == a)) begin
      nTests = nTests + 1;
      nFail  = nFail + 1;
      $display("FAIL %s: request for %0d not seen within %0d cycles", nm, a, budget);
    end
  endtask

  // Compare logged writes from base against the scan order, minus skip
  task automatic checkWrites(input string nm, input int base, input int cntExp,
                             input logic [7:0] skip);
    logic [7:0] a;
    int n;
    chk({nm, "_count"}, 32'(wrN - base), 32'(cntExp));
    n = 0;
    for (int i = 0; i < 11; i++) begin
      a = (i < 10) ? 8'(40 + i) : 8'd51;
      if (a != skip) begin
        if (base + n < 256)
          chk({nm, "_pair"}, {16'd0, wrAddrLog[base + n], wrDataLog[base + n]},
              {16'd0, a, a + 8'd1});
        n++;
      end
    end
  endtask

  int base;
  int dBase;
  int r44;
  int hBase;

  initial begin
    // Cycle table: latency, capture, window-closed hold, stray ack
    vecs[0]  = mk(1, 0, 8'h00,  0, 8'd0,  8'd0,  8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 8'h00,  1, 8'd40, 8'd0,  8'h00, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 8'h5A,  0, 8'd40, 8'd40, 8'h5A, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00,  0, 8'd40, 8'd40, 8'h5A, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00,  1, 8'd41, 8'd40, 8'h5A, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 8'h10,  0, 8'd41, 8'd41, 8'h10, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 8'h00,  0, 8'd41, 8'd41, 8'h10, 0, 1, 0, 0);
    vecs[7]  = mk(0, 0, 8'h00,  1, 8'd42, 8'd41, 8'h10, 0, 1, 0, 0);
    vecs[8]  = mk(1, 1, 8'h77,  0, 8'd42, 8'd42, 8'h77, 0, 1, 0, 0);
    vecs[9]  = mk(1, 0, 8'h00,  0, 8'd42, 8'd42, 8'h77, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 8'h00,  0, 8'd42, 8'd42, 8'h77, 1, 1, 0, 0);
    vecs[11] = mk(0, 0, 8'h00,  0, 8'd42, 8'd42, 8'h77, 0, 1, 0, 0);
    vecs[12] = mk(0, 1, 8'hEE,  1, 8'd43, 8'd42, 8'h77, 0, 1, 0, 0);
    vecs[13] = mk(0, 0, 8'h00,  1, 8'd43, 8'd42, 8'h77, 0, 1, 0, 0);

    // Reset state
    RESET = 1'b1;
    VSync = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", 32'(actual()), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 14; i++) begin
      VSync  = vecs[i].vs;
      tbAck  = vecs[i].ack;
      tbData = vecs[i].data;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
    end
    tbAck = 1'b0;

    // Full scan
    doReset();
    base = wrN; dBase = doneN;
    startScan();
    waitDone("full_scan", dBase, 400);
    cyc(3);
    checkWrites("full", base, 11, 8'd0);
    chk("full_done", 32'(doneN - dBase), 32'd1);
    chk("full_tmo", 32'(TimeoutErr), 32'd0);
    chk("full_busy", 32'(Busy), 32'd0);

    // Timeout on 44
    skipAddr = 8'd44;
    base = wrN; dBase = doneN; r44 = req44N;
    startScan();
    waitDone("timeout_scan", dBase, 400);
    cyc(3);
    skipAddr = 8'd0;
    chk("tmo_req_cycles", 32'(req44N - r44), 32'd15);
    checkWrites("tmo", base, 10, 8'd44);
    chk("tmo_err", 32'(TimeoutErr), 32'd1);
    chk("tmo_done", 32'(doneN - dBase), 32'd1);

    // Sticky error cleared at next start; second fall while busy ignored
    chk("tmo_sticky", 32'(TimeoutErr), 32'd1);
    base = wrN; dBase = doneN;
    startScan();
    cyc(1);
    chk("tmo_cleared", 32'(TimeoutErr), 32'd0);
    chk("busy_started", 32'(Busy), 32'd1);
    cyc(8);
    VSync = 1'b1;
    cyc(2);
    VSync = 1'b0;
    waitDone("double_edge", dBase, 400);
    cyc(40);
    checkWrites("dbl", base, 11, 8'd0);
    chk("dbl_done", 32'(doneN - dBase), 32'd1);
    chk("dbl_busy", 32'(Busy), 32'd0);

    // Window closes as 42 is acked; reopens 100 cycles later
    base = wrN; dBase = doneN; hBase = wrHigh;
    startScan();
    waitReqAddr("win_req42", 8'd42, 100);
    VSync = 1'b1;
    cyc(100);
    chk("win_held_writes", 32'(wrN - base), 32'd2);
    chk("win_held_busy", 32'(Busy), 32'd1);
    chk("win_held_mem", {16'd0, MemAddrOut, MemDataOut}, {16'd0, 8'd42, 8'd43});
    VSync = 1'b0;
    waitDone("window", dBase, 400);
    cyc(3);
    checkWrites("win", base, 11, 8'd0);
    chk("win_done", 32'(doneN - dBase), 32'd1);
    chk("win_no_high_write", 32'(wrHigh - hBase), 32'd0);

    // Reset in the middle of the scan
    base = wrN; dBase = doneN;
    startScan();
    waitReqAddr("rst_req46", 8'd46, 100);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_outs", 32'(actual()), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_partial_writes", 32'(wrN - base), 32'd6);
    base = wrN;
    cyc(20);
    chk("rst_no_write", 32'(wrN - base), 32'd0);
    chk("rst_no_done", 32'(doneN - dBase), 32'd0);
    chk("rst_idle", 32'(Busy), 32'd0);
    startScan();
    waitDone("rst_rescan", dBase, 400);
    cyc(3);
    checkWrites("rst", base, 11, 8'd0);
    chk("rst_done", 32'(doneN - dBase), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/vga_reg_scanner.md
VGA_REG_SCANNER -- requirements
Module: vga_reg_scanner

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles to wait for RdAck per entry.
REQ-002 Parameter NENTRY, default 11, number of entries in the scan table.
REQ-003 CLK  in  1  system clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 VSync  in  1  vertical sync from the timing generator; low = write window open.
REQ-006 RdReq  out  1  read request to the RTC register bus.
REQ-007 RdAddr  out  8  register address being read.
REQ-008 RdData  in  8  read data; valid in the cycle RdAck=1.
REQ-009 RdAck  in  1  read acknowledge, one-cycle pulse.
REQ-010 MemAddrOut  out  8  address to the display pointer stage.
REQ-011 MemDataOut  out  8  data to the display pointer stage.
REQ-012 Write  out  1  one-cycle write strobe to the display pointer stage.
REQ-013 Busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 ScanDone  out  1  one-cycle pulse after the last entry is processed.
REQ-015 TimeoutErr  out  1  sticky; set on any entry timeout, cleared at next scan start.

Function
REQ-016 Scan table order: 40,41,42,43,44,45,46,47,48,49,51 (decimal); address 50 is never accessed.
REQ-017 Falling-edge detection: registered vs_q; fall = vs_q AND NOT VSync.
REQ-018 FSM states: IDLE, REQ, WRITE, NEXT.
REQ-019 IDLE: on fall, index<=0, TimeoutErr<=0, go to REQ next cycle; otherwise stay.
REQ-020 REQ: RdReq=1, RdAddr=table[index]; wait counter increments each cycle.
REQ-021 REQ exit on RdAck=1: capture RdData and RdAddr into MemDataOut/MemAddrOut, clear counter, go to WRITE.
REQ-022 REQ exit on counter==TIMEOUT without ack: set TimeoutErr, skip write, go to NEXT.
REQ-023 RdAck arriving outside REQ is ignored.
REQ-024 WRITE: if VSync=0, Write=1 for exactly one cycle, then go to NEXT.
REQ-025 WRITE: if VSync=1, hold MemAddrOut/MemDataOut and Write=0 until VSync=0.
REQ-026 NEXT: if index==NENTRY-1, ScanDone=1 for one cycle and go to IDLE; else index+1 and go to REQ.
REQ-027 A VSync fall while Busy=1 is ignored; no restart, no queued scan.
REQ-028 Latency: fall detected at cycle t -> RdReq high at t+1; with ack at t+1, Write high at t+2.
REQ-029 MemAddrOut/MemDataOut stay stable from capture until the next capture.
REQ-030 Write is never asserted while VSync=1, at most once per entry, and never outside WRITE.
REQ-031 All outputs are registered; no combinational path from input to output.

Reset
REQ-032 RESET=1 forces IDLE, with index, counter, vs_q, RdReq, RdAddr, MemAddrOut, MemDataOut, Write, Busy, ScanDone and TimeoutErr all 0.
REQ-033 RESET mid-scan abandons the scan; no Write or ScanDone follows until a new VSync fall after reset release.

Structure
REQ-034 Shared package vga_pkg holds the FSM state enum, the scan address table, ADDR_SEG_RELOJ=40 through ADDR_CURSOR_CTL=51, and TIMEOUT default.
REQ-035 The block is a single module; no sub-module.

Verification
REQ-036 Full scan: VSync 1->0, ack 1 cycle after each RdReq with data=addr+1 -> 11 Writes with (40,41)...(49,50),(51,52), then one ScanDone pulse, TimeoutErr=0.
REQ-037 Timeout: no ack for address 44 -> RdReq held exactly 15 cycles, no Write for 44, TimeoutErr=1, scan continues at 45, 10 Writes total.
REQ-038 Window closed: VSync rises while in WRITE for 42 -> Write held low; VSync falls 100 cycles later -> single Write (42,data), scan resumes at 43, no restart.
REQ-039 Reset mid-scan: RESET at entry 46 -> next cycle all outputs 0; no Write until a new VSync fall, then the scan restarts at 40.
REQ-040 Double edge: second VSync fall during Busy -> ignored; exactly 11 Writes and one ScanDone.
